// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: synchronises and majority-filters the UART RX line, flags start edges,
// and times the mid-bit sample strobe while the receive controller holds count_sig.
module uart_rx_sampler #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600,
    parameter int CNT_W    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_pin,
    input  logic count_sig,
    output logic h2l_sig,
    output logic rx_pin_in,
    output logic bps_clk,
    output logic start_err
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int HALF = DIV / 2;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] MID = CNT_W'(HALF - 1);

    if (DIV < 4 || ((DIV - 1) >> CNT_W) != 0) begin : g_bad_cfg
        $error("uart_rx_sampler: DIV must be >= 4 and fit in CNT_W bits");
    end

    logic [1:0] sync_q, sync_d;
    logic [2:0] hist_q, hist_d;
    logic rx_in_q, rx_in_d, h2l_q, h2l_d, bps_q, bps_d, serr_q, serr_d, first_q, first_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic maj, mid;

    always_comb begin
        maj     = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
        mid     = cnt_q == MID;
        sync_d  = {sync_q[0], rx_pin};
        hist_d  = {hist_q[1:0], sync_q[1]};
        rx_in_d = maj;
        h2l_d   = ~count_sig & rx_in_q & ~maj;
        cnt_d   = !count_sig ? '0 : (cnt_q == LAST ? '0 : cnt_q + CNT_W'(1));
        bps_d   = count_sig & mid;
        serr_d  = count_sig & first_q & mid & rx_in_q;
        first_d = !count_sig ? 1'b1 : (mid ? 1'b0 : first_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b11;
            hist_q  <= 3'b111;
            rx_in_q <= 1'b1;
            h2l_q   <= 1'b0;
            bps_q   <= 1'b0;
            serr_q  <= 1'b0;
            cnt_q   <= '0;
            first_q <= 1'b1;
        end else begin
            sync_q  <= sync_d;
            hist_q  <= hist_d;
            rx_in_q <= rx_in_d;
            h2l_q   <= h2l_d;
            bps_q   <= bps_d;
            serr_q  <= serr_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
        end
    end

    assign h2l_sig   = h2l_q;
    assign rx_pin_in = rx_in_q;
    assign bps_clk   = bps_q;
    assign start_err = serr_q;
endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: scoreboarded bench; a sample-history model predicts every pulse and
// the filtered level, a negedge monitor compares them against the DUT.
module tb_uart_rx_sampler;
    localparam int DIV = 10;
    localparam int HALF = 5;
    localparam int N = 8192;

    typedef struct {
        int   n;
        logic h2l, bps, se;
    } ev_t;

    logic clk = 1'b0, rst = 1'b1, rx_pin = 1'b0, count_sig = 1'b0;
    logic h2l_sig, rx_pin_in, bps_clk, start_err;

    ev_t exp_q[$];
    bit  lo[N];
    int  n_edge = 8, run = 0, checks = 0, errors = 0, nh = 0, nb = 0, ne = 0;
    bit  started = 0, exp_in = 1;

    always #5 clk = ~clk;

    uart_rx_sampler #(.CLK_FREQ(1000000), .BAUD(100000), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .rx_pin(rx_pin), .count_sig(count_sig),
        .h2l_sig(h2l_sig), .rx_pin_in(rx_pin_in), .bps_clk(bps_clk), .start_err(start_err)
    );

    // Filtered level after edge n is the 2-of-3 vote over the line sampled at edges n-3..n-5.
    always @(posedge clk) begin : model
        bit nin, h, b, s;
        int lows;
        n_edge++;
        lo[n_edge] = !rx_pin;
        if (rst) begin
            for (int i = 0; i < 5; i++) lo[n_edge-i] = 0;
            nin = 1; h = 0; b = 0; s = 0; run = 0;
            started = 1;
        end else begin
            lows = int'(lo[n_edge-3]) + int'(lo[n_edge-4]) + int'(lo[n_edge-5]);
            nin  = lows < 2;
            h    = !count_sig && exp_in && !nin;
            b    = count_sig && (run % DIV == HALF - 1);
            s    = b && run < DIV && exp_in;
            run  = count_sig ? run + 1 : 0;
        end
        exp_in = nin;
        if (started && (h || b || s)) exp_q.push_back('{n_edge, h, b, s});
    end

    always @(negedge clk) begin : monitor
        ev_t e;
        if (started) begin
            checks++;
            if (rx_pin_in !== exp_in) begin
                errors++;
                $display("FAIL rx_pin_in @edge %0d: got %b expected %b", n_edge, rx_pin_in, exp_in);
            end
            if ({h2l_sig, bps_clk, start_err} !== 3'b000 || (exp_q.size() > 0 && exp_q[0].n == n_edge)) begin
                e = '{n_edge, 1'b0, 1'b0, 1'b0};
                if (exp_q.size() > 0 && exp_q[0].n == n_edge) e = exp_q.pop_front();
                checks++;
                if ({h2l_sig, bps_clk, start_err} !== {e.h2l, e.bps, e.se}) begin
                    errors++;
                    $display("FAIL pulses @edge %0d: got h2l/bps/serr=%b%b%b expected %b%b%b",
                             n_edge, h2l_sig, bps_clk, start_err, e.h2l, e.bps, e.se);
                end
            end
            nh += int'(h2l_sig === 1'b1);
            nb += int'(bps_clk === 1'b1);
            ne += int'(start_err === 1'b1);
        end
    end

    task automatic cyc(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic check_int(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endtask

    initial begin
        int h0, b0, e0;
        cyc(3);
        check_int("reset_rx_pin_in", int'(rx_pin_in), 1);
        check_int("reset_pulses", int'({h2l_sig, bps_clk, start_err}), 0);
        rst = 0; rx_pin = 1;
        cyc(8);
        h0 = nh; rx_pin = 0;
        cyc(10);
        check_int("start_edge_h2l_count", nh - h0, 1);
        check_int("start_edge_level", int'(rx_pin_in), 0);
        rx_pin = 1;
        cyc(8);
        h0 = nh; rx_pin = 0;
        cyc(1);
        rx_pin = 1;
        cyc(8);
        check_int("glitch_h2l_count", nh - h0, 0);
        rx_pin = 0;
        cyc(8);
        b0 = nb; e0 = ne; count_sig = 1;
        cyc(30);
        count_sig = 0;
        cyc(2);
        check_int("frame_low_bps_count", nb - b0, 3);
        check_int("frame_low_serr_count", ne - e0, 0);
        rx_pin = 1;
        cyc(8);
        b0 = nb; e0 = ne; count_sig = 1;
        cyc(8);
        count_sig = 0;
        cyc(4);
        count_sig = 1;
        cyc(10);
        count_sig = 0;
        cyc(2);
        check_int("restart_bps_count", nb - b0, 2);
        check_int("restart_serr_count", ne - e0, 2);
        b0 = nb; e0 = ne; count_sig = 1;
        cyc(3);
        rst = 1;
        cyc(1);
        rst = 0;
        cyc(12);
        count_sig = 0;
        cyc(2);
        check_int("midreset_bps_count", nb - b0, 1);
        check_int("midreset_serr_count", ne - e0, 1);
        repeat (3000) begin
            if ($urandom_range(0, 7) == 0) rx_pin = ~rx_pin;
            if ($urandom_range(0, 24) == 0) count_sig = ~count_sig;
            rst = $urandom_range(0, 399) == 0;
            cyc(1);
        end
        rst = 0; count_sig = 0; rx_pin = 1;
        cyc(10);
        check_int("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
